// File: rtl/ram_dp_be_if.sv
// Bus bundle for ram_dp_be: write port, read port, chip select, clear and status.
// Requests are accepted at a rising edge only while busy is low (busy acts as !ready).
interface ram_dp_be_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) ();
    logic                  cs;
    logic                  clear;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  collision;
    logic [0:0]            fsm_state;

    modport master (
        output cs, clear, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  busy, rd_data, rd_valid, collision, fsm_state
    );

    modport slave (
        input  cs, clear, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output busy, rd_data, rd_valid, collision, fsm_state
    );
endinterface

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with byte enables, write-first forwarding and a zero-fill FSM.
// Optional macro RAM_OUT_REG_EN adds an output register stage (read latency 2).
module ram_dp_be #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic         clock,
    input  logic         reset,
    ram_dp_be_if.slave   bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_addr;
    logic              busy_q;

    logic              accept;
    logic              clr_req;
    logic              wr_fire;
    logic              rd_fire;
    logic              same_addr;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] rd_q;
    logic              rd_v;
    logic              col_q;

    // Requests are only seen in IDLE; clear pre-empts any access in the same cycle.
    assign accept    = bus.cs && (state == ST_IDLE);
    assign clr_req   = accept && bus.clear;
    assign wr_fire   = accept && bus.wr_en && !bus.clear;
    assign rd_fire   = accept && bus.rd_en && !bus.clear;
    assign same_addr = wr_fire && (bus.wr_addr == bus.rd_addr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == {ADDR_W{1'b1}}) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    if (clr_req) begin
                        state    <= ST_CLEAR;
                        busy_q   <= 1'b1;
                        clr_addr <= '0;
                    end
                end
            endcase
        end
    end

    // The array itself carries no reset; the fill FSM defines its contents.
    always_ff @(posedge clock) begin
        if (state == ST_CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.wr_be[i]) begin
                    mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
                end
            end
        end
    end

    // Write-first: enabled lanes of a same-address write override the stored word.
    always_comb begin
        rd_word = mem[bus.rd_addr];
        for (int i = 0; i < BYTES; i++) begin
            if (same_addr && bus.wr_be[i]) begin
                rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            rd_v  <= 1'b0;
            col_q <= 1'b0;
        end else begin
            rd_v  <= rd_fire;
            col_q <= rd_fire && same_addr;
            if (rd_fire) begin
                rd_q <= rd_word;
            end
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_col;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_col   <= 1'b0;
        end else begin
            out_valid <= rd_v;
            out_col   <= col_q;
            if (rd_v) begin
                out_data <= rd_q;
            end
        end
    end

    assign bus.rd_data   = out_data;
    assign bus.rd_valid  = out_valid;
    assign bus.collision = out_col;
`else
    assign bus.rd_data   = rd_q;
    assign bus.rd_valid  = rd_v;
    assign bus.collision = col_q;
`endif

    assign bus.busy      = busy_q;
    assign bus.fsm_state = state;

endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Parametrised simple-dual-port synchronous RAM with one write port, one read port, byte-lane write enables, chip select, write-first read-during-write forwarding and a built-in zero-fill (clear) state machine. It is the general-purpose successor to the team's 8-bit single-port RAM. It replaces the bidirectional data bus with separate read and write buses and is intended for buffers, register files and scratch memories throughout the design.

## Interface
Parameters:
- DATA_W, 8: word width in bits. Must be a multiple of 8.
- ADDR_W, 10: address width. Depth is 2**ADDR_W words.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- cs  in  1  chip select; when low, reads, writes and clear requests are ignored
- clear  in  1  request a zero-fill of the whole array
- busy  out  1  high while zero-fill is in progress
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_be  in  DATA_W/8  byte-lane enables; bit i covers wr_data[8i+7:8i]
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data
- rd_valid  out  1  one-cycle strobe marking new rd_data
- collision  out  1  one-cycle strobe, aligned with rd_valid; read hit the address written in the same cycle

## Operation
- The control FSM has two states, IDLE and CLEAR. It holds a clear address counter clr_addr of ADDR_W bits.
- Reset values: state=CLEAR, clr_addr=0, busy=1, rd_data=0, rd_valid=0, collision=0. Array contents are undefined until the fill completes.
- CLEAR state: each edge writes 0 to mem[clr_addr] and increments clr_addr.
  - On the edge that writes address 2**ADDR_W-1, the FSM moves to IDLE and busy goes to 0.
  - clr_addr wraps to 0.
- In CLEAR, wr_en, rd_en and clear are ignored, and rd_valid stays 0.
- IDLE state, clear request: cs=1 and clear=1 at an edge moves the FSM to CLEAR, sets busy=1 and clr_addr=0.
  - clear has priority: a write or read in the same cycle is dropped.
- IDLE state, write: cs=1, wr_en=1 and clear=0 at an edge updates only the byte lanes of mem[wr_addr] with wr_be[i]=1.
  - wr_be=0 is a legal no-op.
- IDLE state, read: cs=1, rd_en=1 and clear=0 at an edge captures mem[rd_addr] into rd_data and pulses rd_valid.
  - rd_data holds its value when no read is performed.
- Read-during-write, same address: behaviour is write-first.
  - rd_data returns new bytes in enabled lanes and old bytes in the other lanes.
  - collision pulses with rd_valid.
- Read-during-write, different addresses: fully independent.
- Reset asserted mid-clear or mid-access: state returns to reset values immediately, and the fill restarts from address 0 after release.

## Timing
- Read latency is 1 edge: request sampled at edge N, rd_data/rd_valid/collision valid after edge N, for one cycle. With RAM_OUT_REG_EN the latency is 2.
- Writes take effect at the sampling edge. A read of the same address at the next edge returns the new data.
- A full read/write rate of one each per cycle is sustained with no bubbles.
- Fill time is 2**ADDR_W edges.
  - After reset release, busy falls after the 2**ADDR_W-th edge.
  - After a clear request, busy falls 2**ADDR_W edges after the accepting edge.
- busy is registered. Requests are accepted only at edges where busy=0 before the edge.

## Configuration
- RAM_OUT_REG_EN defined: adds one output pipeline register stage.
  - rd_data, rd_valid and collision are delayed by one more cycle, giving a latency of 2.
  - The extra stage resets to 0.
  - Read-data hold is preserved: the output register loads only when the delayed valid is set.
- RAM_OUT_REG_EN undefined: rd_data is driven directly from the array read register, with a latency of 1.

## Test plan
- Settings DATA_W=16, ADDR_W=4, reset released: busy=1 for exactly 16 edges, then 0. Reads of addresses 0..15 return 0x0000, each with a rd_valid pulse.
- Write 0xA5C3 to address 3 with wr_be=2'b11, then read address 3: rd_data=0xA5C3, rd_valid=1 one edge after the read (two with RAM_OUT_REG_EN). Repeat with cs=0 writing 0xFFFF: a read still returns 0xA5C3.
- Byte enable: write 0x1234 to address 3 with wr_be=2'b01, then read: rd_data=0xA534.
- Same cycle: write 0xBEEF to address 3 with wr_be=2'b10 and read address 3. Result: rd_data=0xBE34 and collision=1. A concurrent read of address 4 returns 0x0000 with collision=0.
- Pulse clear with wr_en=1 active through the fill: busy=1 for 16 edges, and the writes during busy have no effect. Address 3 then reads 0x0000.
- Assert reset when clr_addr=7 during a clear: busy stays 1, and the fill restarts at address 0. busy falls 16 edges after release.
